// File: rtl/toccata_pkg.sv
// Shared types and constants for the Toccata playback path.
//   fmt_e           - frame format as programmed by the register file
//   play_state_e    - playback sequencer states
//   bytes_per_frame - FIFO bytes consumed per sample pair for a format
//   UNSIGNED_BIAS   - offset that turns unsigned 8-bit PCM into signed
package toccata_pkg;

    typedef enum logic [1:0] {
        FMT_U8_MONO    = 2'b00,
        FMT_U8_STEREO  = 2'b01,
        FMT_S16_MONO   = 2'b10,
        FMT_S16_STEREO = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPT,
        ST_EMIT
    } play_state_e;

    localparam logic [7:0] UNSIGNED_BIAS = 8'h80;

    function automatic logic [2:0] bytes_per_frame(input fmt_e fmt);
        logic [2:0] n;
        case (fmt)
            FMT_U8_MONO:    n = 3'd1;
            FMT_U8_STEREO:  n = 3'd2;
            FMT_S16_MONO:   n = 3'd2;
            FMT_S16_STEREO: n = 3'd4;
            default:        n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/toccata_sample_unpack.sv
// Combinational frame unpacker: turns up to four FIFO bytes into a signed
// left/right sample pair.
//   fmt         in  - format of the frame being assembled
//   frame_bytes in  - bytes in arrival order, [0] first (left, high byte first)
//   sample_l    out - assembled left sample
//   sample_r    out - assembled right sample (copy of left for mono)
module toccata_sample_unpack
    import toccata_pkg::*;
(
    input  fmt_e             fmt,
    input  logic [3:0][7:0]  frame_bytes,
    output logic [15:0]      sample_l,
    output logic [15:0]      sample_r
);

    always_comb begin
        sample_l = '0;
        sample_r = '0;
        case (fmt)
            FMT_U8_MONO: begin
                sample_l = {frame_bytes[0] ^ UNSIGNED_BIAS, 8'h00};
                sample_r = {frame_bytes[0] ^ UNSIGNED_BIAS, 8'h00};
            end
            FMT_U8_STEREO: begin
                sample_l = {frame_bytes[0] ^ UNSIGNED_BIAS, 8'h00};
                sample_r = {frame_bytes[1] ^ UNSIGNED_BIAS, 8'h00};
            end
            FMT_S16_MONO: begin
                sample_l = {frame_bytes[0], frame_bytes[1]};
                sample_r = {frame_bytes[0], frame_bytes[1]};
            end
            FMT_S16_STEREO: begin
                sample_l = {frame_bytes[0], frame_bytes[1]};
                sample_r = {frame_bytes[2], frame_bytes[3]};
            end
            default: begin
                sample_l = '0;
                sample_r = '0;
            end
        endcase
    end

endmodule

// File: rtl/toccata_play_ctrl.sv
// Toccata playback sequencer. On each codec sample tick it reads one frame
// (1-4 bytes) from the playback FIFO, assembles a left/right sample pair and
// pulses sample_valid. Flags underrun and missed ticks, and raises irq on
// FIFO half-empty or underrun.
//   clk, rst            - clock, synchronous active-high reset
//   play_en, fmt        - playback enable, frame format
//   sample_tick         - codec sample-rate pulse
//   irq_en, irq_ack     - interrupt mask, interrupt clear pulse
//   status_clr          - clears underrun and tick_miss
//   fifo_rd_en          - FIFO read strobe (data arrives the next cycle)
//   fifo_data           - FIFO read data
//   fifo_empty          - FIFO empty flag
//   fifo_half_empty     - pulse when FIFO level drops below half
//   sample_l, sample_r  - assembled signed samples
//   sample_valid        - one-cycle pulse for a new sample pair
//   irq, underrun, tick_miss - interrupt level and sticky status flags
module toccata_play_ctrl
    import toccata_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  play_en,
    input  logic [1:0]            fmt,
    input  logic                  sample_tick,
    input  logic                  irq_en,
    input  logic                  irq_ack,
    input  logic                  status_clr,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_half_empty,
    output logic [15:0]           sample_l,
    output logic [15:0]           sample_r,
    output logic                  sample_valid,
    output logic                  irq,
    output logic                  underrun,
    output logic                  tick_miss
);

    play_state_e               state, next_state;
    fmt_e                      fmt_q;
    logic [2:0]                byte_idx;
    logic [2:0]                next_idx;
    logic [2:0]                frame_n;
    logic [3:0][DATA_WIDTH-1:0] frame_bytes;
    logic [3:0][DATA_WIDTH-1:0] capt_bytes;
    logic [15:0]               asm_l, asm_r;
    logic                      underrun_hit;
    logic                      irq_set;
    logic                      miss_set;

    assign next_idx = byte_idx + 3'd1;
    assign frame_n  = bytes_per_frame(fmt_q);

    // The last byte of a frame is assembled straight from fifo_data so the
    // sample registers can load on the CAPT->EMIT edge without an extra cycle.
    always_comb begin
        capt_bytes = frame_bytes;
        capt_bytes[byte_idx[1:0]] = fifo_data;
    end

    toccata_sample_unpack u_unpack (
        .fmt         (fmt_q),
        .frame_bytes (capt_bytes),
        .sample_l    (asm_l),
        .sample_r    (asm_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        fifo_rd_en   = 1'b0;
        sample_valid = 1'b0;
        underrun_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_tick && play_en) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fifo_rd_en = !fifo_empty;
                if (fifo_empty) begin
                    underrun_hit = play_en;
                    next_state   = ST_EMIT;
                end else begin
                    next_state = ST_CAPT;
                end
            end
            ST_CAPT: begin
                next_state = (next_idx < frame_n) ? ST_FETCH : ST_EMIT;
            end
            ST_EMIT: begin
                sample_valid = 1'b1;
                next_state   = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        // Disabling playback abandons any partial frame.
        if (!play_en) begin
            next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fmt_q       <= FMT_U8_MONO;
            byte_idx    <= '0;
            frame_bytes <= '0;
            sample_l    <= '0;
            sample_r    <= '0;
        end else begin
            if (state == ST_IDLE && next_state == ST_FETCH) begin
                fmt_q    <= fmt_e'(fmt);
                byte_idx <= '0;
            end
            if (state == ST_CAPT && play_en) begin
                frame_bytes <= capt_bytes;
                byte_idx    <= next_idx;
            end
            if (state == ST_CAPT && next_state == ST_EMIT) begin
                sample_l <= asm_l;
                sample_r <= asm_r;
            end
            if (underrun_hit) begin
                frame_bytes <= '0;
                sample_l    <= '0;
                sample_r    <= '0;
            end
        end
    end

    assign irq_set  = irq_en && ((fifo_half_empty && play_en) || underrun_hit);
    assign miss_set = sample_tick && (state != ST_IDLE);

    // Set events take priority over same-cycle clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq       <= 1'b0;
            underrun  <= 1'b0;
            tick_miss <= 1'b0;
        end else begin
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
            if (underrun_hit) begin
                underrun <= 1'b1;
            end else if (status_clr) begin
                underrun <= 1'b0;
            end
            if (miss_set) begin
                tick_miss <= 1'b1;
            end else if (status_clr) begin
                tick_miss <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toccata_play_ctrl.sv
// Self-checking bench for toccata_play_ctrl: a byte FIFO model feeds the
// DUT, and a frame-level reference model predicts read strobes, the
// sample_valid cycle, sample values and flags from format and fill level.
module tb_toccata_play_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play_en = 1'b0;
    logic [1:0]  fmt = 2'b00;
    logic        sample_tick = 1'b0;
    logic        irq_en = 1'b0;
    logic        irq_ack = 1'b0;
    logic        status_clr = 1'b0;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_empty;
    logic        fifo_half_empty = 1'b0;
    logic [15:0] sample_l, sample_r;
    logic        sample_valid, irq, underrun, tick_miss;

    int total = 0;
    int bad = 0;
    logic [15:0] last_l = '0;
    logic [15:0] last_r = '0;

    // FIFO model: wr_ptr owned by stimulus tasks, rd_ptr by the read process.
    logic [7:0]  fmem [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fmem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always #5 clk = ~clk;

    toccata_play_ctrl #(.DATA_WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .play_en         (play_en),
        .fmt             (fmt),
        .sample_tick     (sample_tick),
        .irq_en          (irq_en),
        .irq_ack         (irq_ack),
        .status_clr      (status_clr),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_data       (fifo_data),
        .fifo_empty      (fifo_empty),
        .fifo_half_empty (fifo_half_empty),
        .sample_l        (sample_l),
        .sample_r        (sample_r),
        .sample_valid    (sample_valid),
        .irq             (irq),
        .underrun        (underrun),
        .tick_miss       (tick_miss)
    );

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic int frame_bytes_of(input logic [1:0] f);
        if (f == 2'b00) return 1;
        if (f == 2'b11) return 4;
        return 2;
    endfunction

    function automatic int valid_offset(input int n, input int avail);
        if (avail >= n) return 2 * n + 1;
        return 2 * avail + 2;
    endfunction

    // One tick-driven frame with `avail` bytes in the FIFO; optional extra
    // tick at cycle offset `extra` (0 = none) relative to the accepted tick.
    task automatic run_frame(input logic [1:0] f, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input int avail,
                             input logic ien, input int extra, input string tag);
        logic [7:0]  bb [4];
        int          n, vo, ul, ur;
        logic [15:0] el, er, ol, orr;
        logic        eu, ou, oi;
        logic [15:0] rd_exp, rd_obs, v_exp, v_obs;
        bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
        @(negedge clk);
        status_clr = 1'b1; irq_ack = 1'b1; irq_en = ien; fifo_half_empty = 1'b0;
        @(negedge clk);
        status_clr = 1'b0; irq_ack = 1'b0;
        for (int i = 0; i < avail; i++) push(bb[i]);
        fmt = f;
        sample_tick = 1'b1;

        n  = frame_bytes_of(f);
        vo = valid_offset(n, avail);
        eu = (avail < n);
        if (eu) begin
            el = '0; er = '0;
        end else if (f[1] == 1'b0) begin
            // unsigned 8-bit: recentre around zero, scale to 16 bits
            ul = (int'(bb[0]) - 128) * 256;
            ur = (f == 2'b01) ? (int'(bb[1]) - 128) * 256 : ul;
            el = 16'(ul); er = 16'(ur);
        end else begin
            ul = int'(bb[0]) * 256 + int'(bb[1]);
            ur = (f == 2'b11) ? int'(bb[2]) * 256 + int'(bb[3]) : ul;
            el = 16'(ul); er = 16'(ur);
        end
        rd_exp = '0;
        for (int i = 0; i < n && i < avail; i++) rd_exp[2 * i + 1] = 1'b1;
        v_exp = '0;
        v_exp[vo] = 1'b1;

        rd_obs = '0; v_obs = '0; ol = 'x; orr = 'x; ou = 1'bx; oi = 1'bx;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            sample_tick = (extra != 0 && i == extra);
            if (fifo_rd_en) rd_obs[i] = 1'b1;
            if (sample_valid) begin
                v_obs[i] = 1'b1; ol = sample_l; orr = sample_r; ou = underrun; oi = irq;
            end
        end
        sample_tick = 1'b0;

        total++; if (rd_obs !== rd_exp) begin bad++; $display("FAIL %s rd_en_cycles got=%h want=%h", tag, rd_obs, rd_exp); end
        total++; if (v_obs !== v_exp) begin bad++; $display("FAIL %s valid_cycles got=%h want=%h", tag, v_obs, v_exp); end
        total++; if (ol !== el) begin bad++; $display("FAIL %s sample_l got=%h want=%h", tag, ol, el); end
        total++; if (orr !== er) begin bad++; $display("FAIL %s sample_r got=%h want=%h", tag, orr, er); end
        total++; if (ou !== eu) begin bad++; $display("FAIL %s underrun got=%b want=%b", tag, ou, eu); end
        total++; if (oi !== (eu && ien)) begin bad++; $display("FAIL %s irq got=%b want=%b", tag, oi, eu && ien); end
        total++; if (tick_miss !== (extra != 0)) begin bad++; $display("FAIL %s tick_miss got=%b want=%b", tag, tick_miss, extra != 0); end
        total++; if (wr_ptr != rd_ptr) begin bad++; $display("FAIL %s fifo_left got=%0d want=0", tag, wr_ptr - rd_ptr); end
        wr_ptr = rd_ptr;
        last_l = el; last_r = er;
    endtask

    task automatic check_all_zero(input string tag);
        logic [37:0] got;
        got = {sample_l, sample_r, sample_valid, fifo_rd_en, irq, underrun, tick_miss, 1'b0};
        total++;
        if (got !== '0) begin bad++; $display("FAIL %s outputs got=%h want=0", tag, got); end
    endtask

    task automatic test_reset();
        rst = 1'b1; play_en = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fmt_directed();
        run_frame(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0, 0, "u8_mono_00");
        run_frame(2'b11, 8'h12, 8'h34, 8'hAB, 8'hCD, 4, 1'b0, 0, "s16_stereo");
        run_frame(2'b01, 8'hFF, 8'h01, 8'h00, 8'h00, 2, 1'b0, 0, "u8_stereo");
        run_frame(2'b10, 8'h80, 8'h01, 8'h00, 8'h00, 2, 1'b0, 0, "s16_mono");
    endtask

    task automatic test_underrun();
        run_frame(2'b10, 8'h7F, 8'h00, 8'h00, 8'h00, 1, 1'b1, 0, "underrun");
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clr got=%b want=0", underrun); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b want=1", irq); end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_ack_clr got=%b want=0", irq); end
    endtask

    task automatic test_tick_miss();
        run_frame(2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 4, 1'b0, 4, "tick_miss");
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        total++; if (tick_miss !== 1'b0) begin bad++; $display("FAIL tick_miss_clr got=%b want=0", tick_miss); end
    endtask

    task automatic test_irq_half_empty();
        play_en = 1'b1; irq_en = 1'b1; fifo_half_empty = 1'b1; irq_ack = 1'b1;
        @(negedge clk);
        fifo_half_empty = 1'b0; irq_ack = 1'b0;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL half_empty_set_wins got=%b want=1", irq); end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL half_empty_ack got=%b want=0", irq); end
        irq_en = 1'b0; fifo_half_empty = 1'b1;
        @(negedge clk);
        fifo_half_empty = 1'b0;
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL half_empty_masked got=%b want=0", irq); end
    endtask

    task automatic test_play_drop_and_reset();
        logic [15:0] rd_obs, v_obs;
        @(negedge clk);
        push(8'h11); push(8'h22);
        fmt = 2'b01; sample_tick = 1'b1;
        rd_obs = '0; v_obs = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            if (i == 2) play_en = 1'b0;
            if (fifo_rd_en) rd_obs[i] = 1'b1;
            if (sample_valid) v_obs[i] = 1'b1;
        end
        total++; if (v_obs !== '0) begin bad++; $display("FAIL drop_valid got=%h want=0", v_obs); end
        total++; if (rd_obs !== 16'h0002) begin bad++; $display("FAIL drop_rd_en got=%h want=0002", rd_obs); end
        total++; if ({sample_l, sample_r} !== {last_l, last_r}) begin
            bad++; $display("FAIL drop_hold got=%h want=%h", {sample_l, sample_r}, {last_l, last_r});
        end
        play_en = 1'b1;
        wr_ptr = rd_ptr;

        // mid-frame reset
        irq_en = 1'b1; fifo_half_empty = 1'b1;
        @(negedge clk);
        fifo_half_empty = 1'b0;
        push(8'hA5); push(8'h5A); push(8'hC3); push(8'h3C);
        fmt = 2'b11; sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_frame_reset");
        rst = 1'b0; irq_en = 1'b0;
        repeat (12) begin
            @(negedge clk);
            total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_no_valid got=%b want=0", sample_valid); end
        end
        wr_ptr = rd_ptr;
    endtask

    task automatic test_random();
        logic [1:0] f;
        int n, avail, ex;
        for (int k = 0; k < 40; k++) begin
            f = 2'($urandom_range(0, 3));
            n = frame_bytes_of(f);
            avail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n;
            ex = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, valid_offset(n, avail))) : 0;
            run_frame(f, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      avail, 1'($urandom_range(0, 1)), ex, "random");
        end
    endtask

    initial begin
        test_reset();
        test_fmt_directed();
        test_underrun();
        test_tick_miss();
        test_irq_half_empty();
        test_play_drop_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
